// File: rtl/xfer_sequencer_if.sv
// xfer_sequencer_if: host/device control bus of the transaction sequencer.
//   master modport : the sequencer (takes start/start_addr/ack, drives strobes)
//   slave modport  : host command logic plus device port (the opposite side)
//   start, start_addr : host transaction request and its address
//   ack               : device acknowledge for the write phase
//   busy, ce, wr, req, rd, addr : device-side control bus
//   done, ready, timeout, err   : completion / status back to the host
interface xfer_sequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              ack;

  logic              busy;
  logic              ce;
  logic              wr;
  logic              req;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic              done;
  logic              ready;
  logic              timeout;
  logic              err;

  modport master (
    input  start, start_addr, ack,
    output busy, ce, wr, req, rd, addr, done, ready, timeout, err
  );

  modport slave (
    output start, start_addr, ack,
    input  busy, ce, wr, req, rd, addr, done, ready, timeout, err
  );

endinterface

// File: rtl/xfer_sequencer.sv
// xfer_sequencer: runs one ce / write-handshake / fixed read / done-ready
// transaction per accepted host start on a shared device port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, returns to RST_WAIT with all outputs 0
//   bus   : xfer_sequencer_if master modport (host request, device ack,
//           registered control strobes and status pulses)
// Every output flop is loaded from a decode of the next state, so each strobe
// is valid in the same cycle the state it belongs to is entered.
module xfer_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned CE_DLY  = 2,
  parameter int unsigned RD_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  xfer_sequencer_if.master    bus
);

  localparam int unsigned WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned PMAX   = (RD_HOLD > CE_DLY) ? RD_HOLD : CE_DLY;
  localparam int unsigned PCNT_W = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_RST_WAIT = 3'd0,
    S_IDLE     = 3'd1,
    S_CE_ON    = 3'd2,
    S_WR       = 3'd3,
    S_RD       = 3'd4,
    S_CLOSE    = 3'd5,
    S_READY    = 3'd6,
    S_ABORT    = 3'd7
  } state_e;

  state_e            state_q,   state_d;
  logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
  logic [PCNT_W-1:0] pcnt_q,    pcnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              err_q,     err_d;
  logic              busy_q,    busy_d;
  logic              ce_q,      ce_d;
  logic              wr_q,      wr_d;
  logic              req_q,     req_d;
  logic              rd_q,      rd_d;
  logic              done_q,    done_d;
  logic              ready_q,   ready_d;
  logic              timeout_q, timeout_d;

  // State, counters, latched address and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST_WAIT;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ce_q      <= 1'b0;
      wr_q      <= 1'b0;
      req_q     <= 1'b0;
      rd_q      <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ce_q      <= ce_d;
      wr_q      <= wr_d;
      req_q     <= req_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, counter and status logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    addr_d  = addr_q;
    err_d   = err_q;

    unique case (state_q)
      // pcnt counts sampled edges since reset release.
      S_RST_WAIT: begin
        if (pcnt_q == PCNT_W'(CE_DLY - 1)) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end
      end

      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          err_d   = 1'b0;
          state_d = S_CE_ON;
        end
      end

      S_CE_ON: begin
        wcnt_d  = '0;
        state_d = S_WR;
      end

      // wcnt holds the number of WR cycles already spent without ack;
      // ack wins over the timeout in the last allowed cycle.
      S_WR: begin
        if (bus.ack) begin
          pcnt_d  = '0;
          state_d = S_RD;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end

      S_RD: begin
        if (pcnt_q == PCNT_W'(RD_HOLD - 1)) begin
          pcnt_d  = '0;
          state_d = S_CLOSE;
        end else begin
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end
      end

      S_CLOSE: state_d = S_READY;
      S_READY: state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;

      default: state_d = S_RST_WAIT;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    busy_d    = 1'b0;
    ce_d      = 1'b0;
    wr_d      = 1'b0;
    req_d     = 1'b0;
    rd_d      = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    timeout_d = 1'b0;

    unique case (state_d)
      S_CE_ON: begin
        busy_d = 1'b1;
        ce_d   = 1'b1;
      end
      S_WR: begin
        busy_d = 1'b1;
        ce_d   = 1'b1;
        wr_d   = 1'b1;
        req_d  = 1'b1;
      end
      S_RD: begin
        busy_d = 1'b1;
        ce_d   = 1'b1;
        rd_d   = 1'b1;
      end
      // ce drops here, one cycle after the last rd cycle.
      S_CLOSE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      S_READY: begin
        busy_d  = 1'b1;
        ready_d = 1'b1;
      end
      S_ABORT: timeout_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.ce      = ce_q;
  assign bus.wr      = wr_q;
  assign bus.req     = req_q;
  assign bus.rd      = rd_q;
  assign bus.addr    = addr_q;
  assign bus.done    = done_q;
  assign bus.ready   = ready_q;
  assign bus.timeout = timeout_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// tb_xfer_sequencer: randomized self-checking bench for xfer_sequencer.
// Expected strobes come from a cycle-offset model of one transaction
// (offset t from the start-sampling cycle, ack sampling cycle k).
module tb_xfer_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 8;
  localparam int CE_DLY  = 2;
  localparam int RD_HOLD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  xfer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  xfer_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .CE_DLY (CE_DLY),
    .RD_HOLD(RD_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [ADDR_W-1:0] prev_addr;
  logic              prev_err;

  // Expected {busy, ce, wr, req, rd, done, ready, timeout} at offset t after
  // the start-sampling cycle; k is the cycle ack is sampled, or -1 for none.
  function automatic logic [7:0] model(int t, int k);
    int wr_last;
    wr_last = (k < 0) ? TIMEOUT + 1 : k;
    if (t == 1)                             return 8'b1100_0000;
    if (t >= 2 && t <= wr_last)             return 8'b1111_0000;
    if (k < 0)                              return (t == TIMEOUT + 2) ? 8'b0000_0001 : 8'b0;
    if (t > k && t <= k + RD_HOLD)          return 8'b1100_1000;
    if (t == k + RD_HOLD + 1)               return 8'b1000_0100;
    if (t == k + RD_HOLD + 2)               return 8'b1000_0010;
    return 8'b0;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.busy, bus.ce, bus.wr, bus.req, bus.rd, bus.done, bus.ready, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-on reset, CE_DLY wait with start held high, then an early-ack txn.
  task automatic test_reset();
    logic [7:0] exp;
    bus.start      = 1'b1;
    bus.start_addr = 8'h3C;
    bus.ack        = 1'b0;
    rst_n          = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (outs() !== 8'b0 || bus.addr !== 8'h00 || bus.err !== 1'b0)
      $display("FAIL reset_hold outs=%b addr=%h err=%b required 0", outs(), bus.addr, bus.err);
    else n_pass++;

    rst_n = 1'b1;
    for (int c = 0; c <= 2 + 2 + RD_HOLD + 3; c++) begin
      exp = (c < 3) ? 8'b0 : model(c - 2, 2);
      n_chk++;
      if (outs() !== exp || bus.err !== 1'b0 || bus.addr !== ((c < 3) ? 8'h00 : 8'h3C))
        $display("FAIL reset_release c=%0d outs=%b exp=%b addr=%h err=%b",
                 c, outs(), exp, bus.addr, bus.err);
      else n_pass++;
      bus.start = (c <= 2);
      bus.ack   = (c - 2 == 2);
      tick();
    end
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    prev_addr = 8'h3C;
    prev_err  = 1'b0;
  endtask

  // Directed plan entries followed by randomized back-to-back transactions,
  // with optional start/start_addr/ack noise where they must be ignored.
  task automatic test_transactions();
    int                k, len, gap;
    bit                noise;
    logic [ADDR_W-1:0] a;
    logic [7:0]        exp;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_addr;
    int                r;
    for (int i = 0; i < 28; i++) begin
      a     = ADDR_W'($urandom);
      noise = 1'b0;
      gap   = 0;
      case (i)
        0:       begin a = 8'h5A; k = 4; end
        1:       k = -1;
        2:       k = 9;
        3:       k = 2;
        4:       begin k = 5; noise = 1'b1; end
        5:       begin k = -1; noise = 1'b1; end
        default: begin
          r     = int'($urandom_range(0, 9));
          k     = (r >= 8) ? -1 : 2 + r;
          noise = 1'($urandom_range(0, 1));
          gap   = int'($urandom_range(0, 2));
        end
      endcase
      len = (k < 0) ? TIMEOUT + 3 : k + RD_HOLD + 3;

      for (int g = 0; g < gap; g++) begin
        n_chk++;
        if (outs() !== 8'b0 || bus.err !== prev_err || bus.addr !== prev_addr)
          $display("FAIL idle_gap i=%0d outs=%b addr=%h err=%b required 0/%h/%b",
                   i, outs(), bus.addr, bus.err, prev_addr, prev_err);
        else n_pass++;
        bus.start = 1'b0;
        bus.ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end

      for (int t = 0; t < len; t++) begin
        exp      = model(t, k);
        exp_err  = (t == 0) ? prev_err : (k < 0 && t >= TIMEOUT + 2);
        exp_addr = (t == 0) ? prev_addr : a;
        n_chk++;
        if (outs() !== exp || bus.err !== exp_err || bus.addr !== exp_addr)
          $display("FAIL txn i=%0d k=%0d t=%0d outs=%b exp=%b addr=%h exp=%h err=%b exp=%b",
                   i, k, t, outs(), exp, bus.addr, exp_addr, bus.err, exp_err);
        else n_pass++;

        if (t == 0) begin
          bus.start      = 1'b1;
          bus.start_addr = a;
        end else begin
          bus.start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.start_addr = noise ? ADDR_W'($urandom) : a;
        end
        if (t >= 2 && (k < 0 || t <= k))
          bus.ack = (t == k);
        else
          bus.ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      bus.start = 1'b0;
      bus.ack   = 1'b0;
      prev_addr = a;
      prev_err  = (k < 0);
    end
    n_chk++;
    if (outs() !== 8'b0 || bus.err !== prev_err)
      $display("FAIL txn_final_idle outs=%b err=%b required 0/%b", outs(), bus.err, prev_err);
    else n_pass++;
  endtask

  // Reset asserted during RD: immediate clear, no done/ready, CE_DLY re-enforced.
  task automatic test_reset_mid();
    logic [7:0] exp;
    int         k;
    k = 3;
    for (int t = 0; t <= k + 1; t++) begin
      exp = model(t, k);
      n_chk++;
      if (outs() !== exp)
        $display("FAIL mid_pre t=%0d outs=%b exp=%b", t, outs(), exp);
      else n_pass++;
      bus.start      = (t == 0);
      bus.start_addr = 8'hA7;
      bus.ack        = (t == k);
      if (t < k + 1) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (outs() !== 8'b0 || bus.addr !== 8'h00 || bus.err !== 1'b0)
      $display("FAIL mid_async outs=%b addr=%h err=%b required 0", outs(), bus.addr, bus.err);
    else n_pass++;
    bus.start      = 1'b1;
    bus.start_addr = 8'hC3;
    bus.ack        = 1'b0;
    repeat (2) begin
      tick();
      n_chk++;
      if (outs() !== 8'b0 || bus.addr !== 8'h00)
        $display("FAIL mid_hold outs=%b addr=%h required 0", outs(), bus.addr);
      else n_pass++;
    end

    rst_n = 1'b1;
    for (int c = 0; c <= 2 + 4 + RD_HOLD + 3; c++) begin
      exp = (c < 3) ? 8'b0 : model(c - 2, 4);
      n_chk++;
      if (outs() !== exp || bus.addr !== ((c < 3) ? 8'h00 : 8'hC3))
        $display("FAIL mid_release c=%0d outs=%b exp=%b addr=%h", c, outs(), exp, bus.addr);
      else n_pass++;
      bus.start = (c <= 2);
      bus.ack   = (c - 2 == 4);
      tick();
    end
    bus.start = 1'b0;
    bus.ack   = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.ack        = 1'b0;
    prev_addr      = '0;
    prev_err       = 1'b0;
    test_reset();
    test_transactions();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xfer_sequencer.md
# xfer_sequencer

Transaction sequencer driving the ce/wr/rd/req/addr control bus of a single shared device port. Accepts one host start at a time, then:
- raises ce;
- issues a write phase with a req/ack handshake under a watchdog timeout;
- issues a fixed-length read phase with a stable address;
- closes the transaction with done then ready.

It sits between the host command logic and the device port, and produces exactly the sequences the team's assertion suite checks.

## Interface
Parameters:
- ADDR_W, 8, address width
- TIMEOUT, 100, max WR-state cycles waiting for ack (≥1)
- CE_DLY, 2, cycles after reset release before start is accepted (1..3)
- RD_HOLD, 2, cycles rd stays high per transaction (≥2)

Ports (clock and reset):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset

Ports (host side):
- start  in  1  transaction request, sampled only in IDLE
- start_addr  in  ADDR_W  address, latched with start

Ports (device side):
- ack  in  1  device acknowledge, sampled only in WR

Ports (outputs):
- busy  out  1  transaction in progress
- ce  out  1  chip enable, high for whole transaction
- wr  out  1  write strobe
- req  out  1  request, high with wr
- rd  out  1  read strobe
- addr  out  ADDR_W  latched address
- done  out  1  one-cycle pulse at transaction end
- ready  out  1  one-cycle pulse, cycle after done
- timeout  out  1  one-cycle pulse on ack timeout
- err  out  1  sticky timeout flag, cleared by next accepted start

## Operation
All outputs are registered. Reset (rst_n low) immediately forces every output to 0, addr to 0, the counters to 0, and the state to RST_WAIT. This holds mid-transaction; no done, ready or timeout is emitted on reset.

States and transitions:
- RST_WAIT: count CE_DLY cycles after rst_n release, then go to IDLE. start is ignored.
- IDLE: all strobes low. start=1: latch start_addr into addr, clear err, go to CE_ON.
- CE_ON (1 cycle): ce=1, busy=1, go to WR.
- WR: ce=wr=req=1. Wait counter increments each WR cycle.
  - ack=1: go to RD. ack beats the timeout if both occur in the same cycle.
  - Counter reaches TIMEOUT with no ack: go to ABORT.
- RD: ce=rd=1 for exactly RD_HOLD cycles; wr=req=0. Then go to CLOSE.
- CLOSE (1 cycle): ce=0, done=1, go to READY.
- READY (1 cycle): ready=1, busy=1, go to IDLE.
- ABORT (1 cycle): ce=wr=req=0, timeout=1, err=1, busy=0, go to IDLE.

Other rules:
- addr is held constant from CE_ON through READY. It changes only on an accepted start.
- ack outside WR is ignored. start outside IDLE is ignored and is not queued.
- Wait counter width is $clog2(TIMEOUT+1). It is cleared on entry to WR and never wraps.
- rd and wr are never high in the same cycle.
- ce always falls at least one cycle after the last rd cycle.

## Timing
Take start sampled high in IDLE at cycle 0:
- cycle 1: ce=1, busy=1 (CE_ON)
- cycle 2: wr=req=1 (first WR cycle). An ack already high here is accepted.
- ack sampled at cycle k:
  - cycles k+1 .. k+RD_HOLD: wr=req=0, rd=1
  - cycle k+RD_HOLD+1: ce=0, done=1
  - cycle k+RD_HOLD+2: ready=1
  - cycle k+RD_HOLD+3: IDLE; the earliest next start is sampled here.
- Minimum latency from start to ready is RD_HOLD+4 cycles (k=2).
- No ack in cycles 2..TIMEOUT+1: at cycle TIMEOUT+2, ce=wr=req=0, timeout=1, err=1. IDLE from TIMEOUT+3.
- busy=1 from CE_ON through READY inclusive; 0 in ABORT.
- After rst_n rises at cycle r, the first start is accepted at cycle r+CE_DLY.

## Test plan
Parameters for all scenarios: TIMEOUT=8, CE_DLY=2, RD_HOLD=2.
- Reset release: rst_n rises at cycle 0, start held high from cycle 0.
  - Start is accepted at cycle 2 and ce=1 at cycle 3.
  - All outputs are 0 before cycle 3.
- Nominal transaction: start with start_addr=0x5A, ack high on the 3rd WR cycle (cycle 4).
  - rd=1 at cycles 5–6 with addr=0x5A; ce=0 and done=1 at cycle 7; ready=1 at cycle 8.
- Timeout: start, ack held low.
  - wr/req high for cycles 2–9; timeout=1, err=1 and ce=0 at cycle 10.
  - No done or ready.
  - The next start clears err at acceptance.
- Ack/timeout collision and early ack:
  - ack first rises on the 8th WR cycle: RD is taken, no timeout.
  - ack high at cycle 2: rd=1 at cycles 3–4.
- Reset mid-operation: rst_n low during RD.
  - All outputs are 0 asynchronously, no done or ready.
  - After release, the CE_DLY wait is enforced again.
- Ignored inputs:
  - start pulses during WR/RD and ack pulses in IDLE/RD cause no change.
  - addr stays stable and exactly one done/ready pair is produced.
